// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: field widths, the bubble word and small helpers
// used by the fetch unit and its PC calculator.
package mips_pkg;

  localparam int WORD_W = 32;
  localparam int IMM_W  = 16;
  localparam int JIDX_W = 26;

  // sll $0,$0,0 -- the canonical MIPS no-op
  localparam logic [WORD_W-1:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } fetch_state_t;

  typedef enum logic [1:0] {
    SEL_SEQ    = 2'd0,
    SEL_BRANCH = 2'd1,
    SEL_JUMP   = 2'd2
  } pc_sel_t;

  typedef enum logic [1:0] {
    ACT_SEQ      = 2'd0,
    ACT_HOLD     = 2'd1,
    ACT_END      = 2'd2,
    ACT_REDIRECT = 2'd3
  } fetch_act_t;

  function automatic logic [WORD_W-1:0] sext16to32(input logic [IMM_W-1:0] imm);
    return {{(WORD_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: sequential, taken branch or jump target.
// Redirects only count when the instruction in IF/ID is a real one.
module pc_next_calc
  import mips_pkg::*;
(
  input  logic [WORD_W-1:0] pc,
  input  logic [WORD_W-1:0] if_id_pc,
  input  logic              if_id_valid,
  input  logic              branch_taken,
  input  logic [IMM_W-1:0]  branch_offset,
  input  logic              jump,
  input  logic [JIDX_W-1:0] jump_index,
  output logic [WORD_W-1:0] seq_pc,
  output logic [WORD_W-1:0] target,
  output pc_sel_t           sel
);

  logic [WORD_W-1:0] if_id_pc_plus1;
  logic [WORD_W-1:0] branch_target;
  logic [WORD_W-1:0] jump_target;

  assign seq_pc         = pc + 32'd1;
  assign if_id_pc_plus1 = if_id_pc + 32'd1;
  assign branch_target  = if_id_pc_plus1 + sext16to32(branch_offset);
  // Word-indexed J/JAL: upper bits come from the delay-slot PC, low 26 from the index
  assign jump_target    = {if_id_pc_plus1[WORD_W-1:JIDX_W], jump_index};

  always_comb begin
    sel    = SEL_SEQ;
    target = seq_pc;
    if (if_id_valid && jump) begin
      sel    = SEL_JUMP;
      target = jump_target;
    end else if (if_id_valid && branch_taken) begin
      sel    = SEL_BRANCH;
      target = branch_target;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads IMEM combinationally and loads IF/ID,
// applying redirect > stall > end-of-program > sequential priority each edge.
module instruction_fetch_unit
  import mips_pkg::*;
#(
  parameter int unsigned       IMEM_DEPTH = 7,
  parameter logic [31:0]       RESET_PC   = 32'd0,
  parameter logic [31:0]       NOP_WORD   = mips_pkg::NOP_WORD
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic [WORD_W-1:0]    imem_pc,
  input  logic [WORD_W-1:0]    imem_instr,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  logic [IMM_W-1:0]     branch_offset,
  input  logic                 jump,
  input  logic [JIDX_W-1:0]    jump_index,
  output logic [WORD_W-1:0]    if_id_instr,
  output logic [WORD_W-1:0]    if_id_pc,
  output logic                 if_id_valid,
  output logic                 fetch_done,
  output logic [WORD_W-1:0]    fetch_count
);

  localparam logic [WORD_W-1:0] DEPTH = WORD_W'(IMEM_DEPTH);

  logic [WORD_W-1:0] pc;
  logic [WORD_W-1:0] seq_pc;
  logic [WORD_W-1:0] target;
  pc_sel_t           sel;
  fetch_state_t      state;
  fetch_state_t      next_state;
  fetch_act_t        act;

  pc_next_calc u_pc_next_calc (
    .pc            (pc),
    .if_id_pc      (if_id_pc),
    .if_id_valid   (if_id_valid),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_index    (jump_index),
    .seq_pc        (seq_pc),
    .target        (target),
    .sel           (sel)
  );

  assign imem_pc    = pc;
  assign fetch_done = (state == ST_DONE);

  always_comb begin
    act        = ACT_SEQ;
    next_state = state;
    if (sel != SEL_SEQ) begin
      act = ACT_REDIRECT;
      // A redirect past the end leaves DONE as is; the end check catches it next edge
      if (target < DEPTH) next_state = ST_RUN;
    end else if (stall) begin
      act = ACT_HOLD;
    end else if (pc >= DEPTH) begin
      act        = ACT_END;
      next_state = ST_DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      if_id_instr <= NOP_WORD;
      if_id_pc    <= '0;
      if_id_valid <= 1'b0;
      fetch_count <= '0;
    end else begin
      case (act)
        ACT_SEQ: begin
          pc          <= seq_pc;
          if_id_instr <= imem_instr;
          if_id_pc    <= pc;
          if_id_valid <= 1'b1;
          fetch_count <= fetch_count + 32'd1;
        end
        ACT_REDIRECT: begin
          pc          <= target;
          if_id_instr <= NOP_WORD;
          if_id_pc    <= '0;
          if_id_valid <= 1'b0;
        end
        ACT_END: begin
          if_id_instr <= NOP_WORD;
          if_id_pc    <= '0;
          if_id_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
